// File: rtl/seq_det_pkg.sv
// Shared types and default parameters for the programmable serial-pattern
// detector (seq_detector_prog and its seq_det_window sub-module).
//   state_e      : detector FSM state encoding
//   DEF_MAX_LEN  : default maximum pattern length in bits
//   DEF_CNT_W    : default match-counter width
package seq_det_pkg;

    typedef enum logic [1:0] {
        UNCONFIG = 2'b00,
        HUNT     = 2'b01,
        MATCH    = 2'b10
    } state_e;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_det_window.sv
// History window for the serial-pattern detector: shift register of the most
// recent bits, saturating fill counter and masked pattern compare.
//   clk_i      : clock (rising edge)
//   rst_i      : synchronous active-high reset
//   clr_i      : clear history and fill (configuration load)
//   shift_i    : accept bit_i this edge
//   bit_i      : incoming serial bit
//   overlap_i  : 1 = keep fill after a hit, 0 = restart fill after a hit
//   pattern_i  : latched pattern, pattern_i[0] compares against the newest bit
//   len_i      : latched pattern length
//   hit_o      : combinational; bit_i would complete a match if accepted
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic               bit_i,
    input  logic               overlap_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_next, mask;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W:0]     fill_inc;

    always_comb begin
        hist_next = {hist_q[MAX_LEN-2:0], bit_i};
        fill_inc  = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};

        // Only the lowest len_i history bits take part in the compare.
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_i);
        end

        hit_o = (fill_inc >= {1'b0, len_i}) &&
                (((hist_next ^ pattern_i) & mask) == '0);

        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = hist_next;
            // Non-overlapping mode: the next match must be built from fresh bits.
            if (hit_o && !overlap_i) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_inc[LEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial-pattern detector with runtime-loaded pattern, selectable
// overlapping detection, registered Moore match output and saturating counter.
//   clock        : clock (rising edge)
//   reset        : synchronous active-high reset
//   sequence_in  : serial data bit
//   in_valid     : sequence_in is sampled when high
//   cfg_load     : latch pattern / pat_len / overlap (wins over in_valid)
//   pattern      : pattern[pat_len-1] is the first bit, pattern[0] the last
//   pat_len      : pattern length, legal 1..MAX_LEN
//   overlap      : 1 = overlapping detection
//   detector_out : high for one cycle per match (registered)
//   match_count  : matches since last load/reset, saturating
//   cfg_error    : sticky, set by a load with illegal pat_len
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter  int unsigned CNT_W   = DEF_CNT_W,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_error
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               win_clr, win_shift, hit;
    logic               len_legal;

    seq_det_window #(
        .MAX_LEN (MAX_LEN)
    ) u_window (
        .clk_i     (clock),
        .rst_i     (reset),
        .clr_i     (win_clr),
        .shift_i   (win_shift),
        .bit_i     (sequence_in),
        .overlap_i (ovl_q),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .hit_o     (hit)
    );

    assign len_legal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        win_clr   = 1'b0;
        win_shift = 1'b0;

        if (cfg_load) begin
            win_clr = 1'b1;
            cnt_d   = '0;
            if (len_legal) begin
                pat_d   = pattern;
                len_d   = pat_len;
                ovl_d   = overlap;
                err_d   = 1'b0;
                state_d = HUNT;
            end else begin
                err_d   = 1'b1;
                state_d = UNCONFIG;
            end
        end else begin
            unique case (state_q)
                HUNT, MATCH: begin
                    state_d = HUNT;
                    if (in_valid) begin
                        win_shift = 1'b1;
                        if (hit) begin
                            state_d = MATCH;
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_d = UNCONFIG;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= UNCONFIG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Moore output: high exactly in the cycle after a matching bit.
    assign detector_out = (state_q == MATCH);
    assign match_count  = cnt_q;
    assign cfg_error    = err_q;

endmodule
